// File: rtl/mmr_bank_responder_pkg.sv
// Shared definitions for the MMR bank responder: register map indices,
// legal bank sizes and the per-port request state encoding.
package mmr_bank_responder_pkg;

  localparam int IDX_W        = 6;
  localparam int NUM_REGS_MIN = 5;
  localparam int NUM_REGS_MAX = 64;

  localparam int CTRL_IDX     = 0;
  localparam int STATUS_IDX   = 1;
  localparam int IRQ_PEND_IDX = 2;
  localparam int IRQ_MASK_IDX = 3;
  localparam int DOORBELL_IDX = 4;
  localparam int SCRATCH_IDX  = 5;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACCESS  = 2'd1,
    ST_RESPOND = 2'd2
  } port_state_e;

endpackage

// File: rtl/mmr_bank_responder_if.sv
// One MMR request/response port: request fields from the address decode,
// completion strobe and read data back to the requester.
interface mmr_bank_responder_if #(parameter int DATA_W = 32);

  logic              EnableMmr;
  logic [7:0]        AddrMmr;
  logic              WrEn;
  logic [DATA_W-1:0] WrData;
  logic              rda;
  logic [DATA_W-1:0] RdData;

  modport master (output EnableMmr, AddrMmr, WrEn, WrData, input rda, RdData);
  modport slave  (input EnableMmr, AddrMmr, WrEn, WrData, output rda, RdData);

endinterface

// File: rtl/mmr_bank_responder_port_fsm.sv
// Per-port request sequencer: captures a request in IDLE, performs the bank
// access in ACCESS (held off by stall_i), strobes rda with read data in RESPOND.
module mmr_port_fsm
  import mmr_bank_responder_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic                 Clk,
  input  logic                 Rst_n,
  mmr_bank_responder_if.slave  bus,
  input  logic                 stall_i,
  input  logic [DATA_W-1:0]    rd_value_i,
  output logic                 in_access_o,
  output logic                 fire_o,
  output logic [IDX_W-1:0]     idx_o,
  output logic                 wr_o,
  output logic [DATA_W-1:0]    wdata_o
);

  port_state_e       state_q, state_d;
  logic [IDX_W-1:0]  idx_q;
  logic              wr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic              rda;
  logic              unused_addr_lsbs;

  assign unused_addr_lsbs = ^bus.AddrMmr[1:0];

  always_comb begin
    state_d = state_q;
    fire_o  = 1'b0;
    unique case (state_q)
      ST_IDLE:    if (bus.EnableMmr) state_d = ST_ACCESS;
      ST_ACCESS:  if (!stall_i) begin
                    fire_o  = 1'b1;
                    state_d = ST_RESPOND;
                  end
      ST_RESPOND: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      wr_q    <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_IDLE && bus.EnableMmr) begin
        idx_q   <= bus.AddrMmr[7:2];
        wr_q    <= bus.WrEn;
        wdata_q <= bus.WrData;
      end
      // Read value is sampled on the same edge the bank is written: pre-write data.
      if (fire_o) rdata_q <= wr_q ? '0 : rd_value_i;
    end
  end

  assign rda         = (state_q == ST_RESPOND);
  assign bus.rda     = rda;
  assign bus.RdData  = rda ? rdata_q : '0;
  assign in_access_o = (state_q == ST_ACCESS);
  assign idx_o       = idx_q;
  assign wr_o        = wr_q;
  assign wdata_o     = wdata_q;

endmodule

// File: rtl/mmr_bank_responder.sv
// Two-port MMR register bank with sampled status, W1C interrupt pending/mask,
// registered IRQ output and a doorbell write pulse.
module mmr_bank_responder
  import mmr_bank_responder_pkg::*;
#(
  parameter int NUM_REGS = 16,
  parameter int DATA_W   = 32
) (
  input  logic                Clk,
  input  logic                Rst_n,
  mmr_bank_responder_if.slave port0,
  mmr_bank_responder_if.slave port1,
  input  logic [DATA_W-1:0]   PeriphStatus,
  input  logic [DATA_W-1:0]   PeriphIrq,
  output logic                DoorbellPulse,
  output logic [DATA_W-1:0]   DoorbellData,
  output logic                IrqOut
);

  if (NUM_REGS < NUM_REGS_MIN || NUM_REGS > NUM_REGS_MAX) begin : g_bad_num_regs
    $error("mmr_bank_responder: NUM_REGS out of range");
  end

  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] regs_d [NUM_REGS];
  logic              acc0, acc1, fire0, fire1, wr0, wr1, we0, we1, stall1;
  logic [IDX_W-1:0]  idx0, idx1;
  logic [DATA_W-1:0] wd0, wd1, rv0, rv1, w1c;
  logic              db_pulse_q, db_pulse_d, irq_q, irq_d;
  logic [DATA_W-1:0] db_data_q, db_data_d;

  mmr_port_fsm #(.DATA_W(DATA_W)) u_port0 (
    .Clk(Clk), .Rst_n(Rst_n), .bus(port0), .stall_i(1'b0), .rd_value_i(rv0),
    .in_access_o(acc0), .fire_o(fire0), .idx_o(idx0), .wr_o(wr0), .wdata_o(wd0)
  );

  mmr_port_fsm #(.DATA_W(DATA_W)) u_port1 (
    .Clk(Clk), .Rst_n(Rst_n), .bus(port1), .stall_i(stall1), .rd_value_i(rv1),
    .in_access_o(acc1), .fire_o(fire1), .idx_o(idx1), .wr_o(wr1), .wdata_o(wd1)
  );

  // Same-word collision with any write: port 0 goes first, port 1 waits a cycle.
  assign stall1 = acc0 && acc1 && (idx0 == idx1) && (wr0 || wr1);
  assign we0    = fire0 && wr0;
  assign we1    = fire1 && wr1;

  always_comb begin
    rv0 = '0;
    rv1 = '0;
    for (int k = 0; k < NUM_REGS; k++) begin
      if (k != DOORBELL_IDX) begin
        if (idx0 == IDX_W'(k)) rv0 = regs_q[k];
        if (idx1 == IDX_W'(k)) rv1 = regs_q[k];
      end
    end
  end

  always_comb begin
    w1c = '0;
    if (we0 && idx0 == IDX_W'(IRQ_PEND_IDX)) w1c = w1c | wd0;
    if (we1 && idx1 == IDX_W'(IRQ_PEND_IDX)) w1c = w1c | wd1;
    for (int k = 0; k < NUM_REGS; k++) begin
      regs_d[k] = regs_q[k];
      if (k == STATUS_IDX) begin
        regs_d[k] = PeriphStatus;
      end else if (k == IRQ_PEND_IDX) begin
        regs_d[k] = (regs_q[k] & ~w1c) | PeriphIrq;
      end else if (k != DOORBELL_IDX) begin
        if (we0 && idx0 == IDX_W'(k)) regs_d[k] = wd0;
        if (we1 && idx1 == IDX_W'(k)) regs_d[k] = wd1;
      end
    end
  end

  always_comb begin
    db_pulse_d = 1'b0;
    db_data_d  = db_data_q;
    if (we0 && idx0 == IDX_W'(DOORBELL_IDX)) begin
      db_pulse_d = 1'b1;
      db_data_d  = wd0;
    end
    if (we1 && idx1 == IDX_W'(DOORBELL_IDX)) begin
      db_pulse_d = 1'b1;
      db_data_d  = wd1;
    end
    irq_d = |(regs_q[IRQ_PEND_IDX] & regs_q[IRQ_MASK_IDX]);
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      for (int k = 0; k < NUM_REGS; k++) regs_q[k] <= '0;
      db_pulse_q <= 1'b0;
      db_data_q  <= '0;
      irq_q      <= 1'b0;
    end else begin
      for (int k = 0; k < NUM_REGS; k++) regs_q[k] <= regs_d[k];
      db_pulse_q <= db_pulse_d;
      db_data_q  <= db_data_d;
      irq_q      <= irq_d;
    end
  end

  assign DoorbellPulse = db_pulse_q;
  assign DoorbellData  = db_data_q;
  assign IrqOut        = irq_q;

endmodule

// File: tb/tb_mmr_bank_responder.sv
// Directed and randomized checks of mmr_bank_responder against a register-map
// reference model kept in the bench.
module tb_mmr_bank_responder;

  logic        Clk = 1'b0;
  logic        Rst_n;
  logic [31:0] PeriphStatus, PeriphIrq, DoorbellData;
  logic        DoorbellPulse, IrqOut;

  mmr_bank_responder_if #(.DATA_W(32)) p0_if ();
  mmr_bank_responder_if #(.DATA_W(32)) p1_if ();

  always #5 Clk = ~Clk;

  mmr_bank_responder #(.NUM_REGS(16), .DATA_W(32)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .port0(p0_if.slave), .port1(p1_if.slave),
    .PeriphStatus(PeriphStatus), .PeriphIrq(PeriphIrq),
    .DoorbellPulse(DoorbellPulse), .DoorbellData(DoorbellData), .IrqOut(IrqOut)
  );

  int tests  = 0;
  int failed = 0;

  // Reference model: plain array of register contents plus doorbell state.
  logic [31:0] m_regs [64];
  logic [31:0] m_status, m_db;
  int          m_pulses;
  int          last_cyc0, last_pcyc;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  function automatic void m_reset();
    for (int i = 0; i < 64; i++) m_regs[i] = '0;
    m_db = '0;
  endfunction

  function automatic logic [31:0] mread(input int idx);
    if (idx >= 16 || idx == 4) return '0;
    if (idx == 1) return m_status;
    return m_regs[idx];
  endfunction

  function automatic void mwrite(input int idx, input logic [31:0] d);
    if (idx >= 16 || idx == 1) return;
    if (idx == 2)      m_regs[2] = m_regs[2] & ~d;
    else if (idx == 4) begin m_db = d; m_pulses++; end
    else               m_regs[idx] = d;
  endfunction

  task automatic run_pair(input string tag,
                          input bit e0, input logic [7:0] a0, input bit w0, input logic [31:0] d0,
                          input bit e1, input logic [7:0] a1, input bit w1, input logic [31:0] d1,
                          input logic [31:0] irq_acc);
    int i0, i1, n0, n1, c0, c1, np;
    bit conflict, idle_bad;
    logic [31:0] er0, er1, r0, r1;
    i0 = int'(a0[7:2]);
    i1 = int'(a1[7:2]);
    conflict = e0 && e1 && (i0 == i1) && (w0 || w1);
    m_pulses = 0;
    er0 = mread(i0);
    er1 = mread(i1);
    if (e0 && w0) mwrite(i0, d0);
    if (conflict) er1 = mread(i1);
    if (e1 && w1) mwrite(i1, d1);
    m_regs[2] = m_regs[2] | irq_acc;

    p0_if.EnableMmr = e0; p0_if.AddrMmr = a0; p0_if.WrEn = w0; p0_if.WrData = d0;
    p1_if.EnableMmr = e1; p1_if.AddrMmr = a1; p1_if.WrEn = w1; p1_if.WrData = d1;
    n0 = 0; n1 = 0; c0 = 0; c1 = 0; np = 0; r0 = '0; r1 = '0; idle_bad = 1'b0;
    last_pcyc = 0;
    for (int c = 1; c <= 6; c++) begin
      tick();
      PeriphIrq = (c == 1) ? irq_acc : '0;
      if (p0_if.rda) begin n0++; c0 = c; r0 = p0_if.RdData; p0_if.EnableMmr = 1'b0; end
      else if (p0_if.RdData !== '0) idle_bad = 1'b1;
      if (p1_if.rda) begin n1++; c1 = c; r1 = p1_if.RdData; p1_if.EnableMmr = 1'b0; end
      else if (p1_if.RdData !== '0) idle_bad = 1'b1;
      if (DoorbellPulse) begin np++; last_pcyc = c; end
    end
    PeriphIrq = '0;
    last_cyc0 = c0;
    check({tag, ".rda0_cnt"}, n0, e0 ? 1 : 0);
    check({tag, ".rda1_cnt"}, n1, e1 ? 1 : 0);
    if (e0) check({tag, ".lat0"}, c0, 2);
    if (e1) check({tag, ".lat1"}, c1, conflict ? 3 : 2);
    if (e0 && !w0) check({tag, ".rd0"}, r0, er0);
    if (e1 && !w1) check({tag, ".rd1"}, r1, er1);
    check({tag, ".rddata_idle"}, idle_bad, 1'b0);
    check({tag, ".db_pulses"}, np, m_pulses);
    check({tag, ".db_data"}, DoorbellData, m_db);
    tick();
    tick();
    check({tag, ".irq"}, IrqOut, |(m_regs[2] & m_regs[3]));
  endtask

  initial begin
    bit e0, e1, w0, w1;
    int x0, x1;
    logic [7:0]  a0, a1;
    logic [31:0] irq_acc;
    int n;

    Rst_n = 1'b0;
    PeriphStatus = '0; PeriphIrq = '0; m_status = '0;
    p0_if.EnableMmr = 1'b0; p0_if.AddrMmr = '0; p0_if.WrEn = 1'b0; p0_if.WrData = '0;
    p1_if.EnableMmr = 1'b0; p1_if.AddrMmr = '0; p1_if.WrEn = 1'b0; p1_if.WrData = '0;
    m_reset();
    tick(); tick();
    check("reset.rda0", p0_if.rda, 1'b0);
    check("reset.rda1", p1_if.rda, 1'b0);
    check("reset.irq", IrqOut, 1'b0);
    check("reset.db_pulse", DoorbellPulse, 1'b0);
    check("reset.db_data", DoorbellData, 32'h0);
    Rst_n = 1'b1;
    tick();

    // Reset arriving while port 0 is mid-ACCESS discards the write.
    p0_if.EnableMmr = 1'b1; p0_if.AddrMmr = 8'h14; p0_if.WrEn = 1'b1; p0_if.WrData = 32'hDEAD;
    tick();
    Rst_n = 1'b0;
    #1;
    check("rstmid.rda0", p0_if.rda, 1'b0);
    tick(); tick();
    p0_if.EnableMmr = 1'b0;
    Rst_n = 1'b1;
    m_reset();
    n = 0;
    for (int c = 0; c < 4; c++) begin tick(); if (p0_if.rda) n++; end
    check("rstmid.no_rda", n, 0);
    run_pair("rstmid.rd14", 1, 8'h14, 0, '0, 0, '0, 0, '0, '0);

    run_pair("t2.wr", 1, 8'h00, 1, 32'h12345678, 0, '0, 0, '0, '0);
    run_pair("t2.rd", 1, 8'h00, 0, '0, 0, '0, 0, '0, '0);

    run_pair("t3.wrwr", 1, 8'h14, 1, 32'hA, 1, 8'h14, 1, 32'hB, '0);
    run_pair("t3.rd", 1, 8'h14, 0, '0, 0, '0, 0, '0, '0);
    check("t3.val", m_regs[5], 32'hB);

    run_pair("t4.mask", 1, 8'h0C, 1, 32'h4, 0, '0, 0, '0, '0);
    PeriphIrq = 32'h4;
    tick();
    PeriphIrq = '0;
    m_regs[2] = m_regs[2] | 32'h4;
    tick();
    check("t4.irq_set", IrqOut, 1'b1);
    run_pair("t4.w1c_race", 1, 8'h08, 1, 32'h4, 0, '0, 0, '0, 32'h4);
    run_pair("t4.rdpend", 0, '0, 0, '0, 1, 8'h08, 0, '0, '0);
    check("t4.pend", m_regs[2], 32'h4);

    run_pair("t5.db", 1, 8'h10, 1, 32'h55, 0, '0, 0, '0, '0);
    check("t5.pulse_with_rda", last_pcyc, last_cyc0);
    check("t5.db_val", DoorbellData, 32'h55);
    run_pair("t5.rd", 1, 8'h10, 0, '0, 0, '0, 0, '0, '0);

    run_pair("t6.rd_oob", 1, 8'hFC, 0, '0, 0, '0, 0, '0, '0);
    run_pair("t6.wr_oob", 1, 8'hFC, 1, 32'hCAFEF00D, 0, '0, 0, '0, '0);
    run_pair("t6.rd_oob2", 0, '0, 0, '0, 1, 8'hFC, 0, '0, '0);

    run_pair("t7.db2", 1, 8'h10, 1, 32'h111, 1, 8'h10, 1, 32'h222, '0);
    check("t7.db_val", DoorbellData, 32'h222);

    for (int it = 0; it < 40; it++) begin
      PeriphStatus = $urandom;
      m_status = PeriphStatus;
      tick();
      e0 = 1'($urandom_range(0, 1));
      e1 = 1'($urandom_range(0, 1));
      if (!e0 && !e1) e0 = 1'b1;
      w0 = 1'($urandom_range(0, 1));
      w1 = 1'($urandom_range(0, 1));
      x0 = $urandom_range(0, 17);
      x0 = (x0 == 17) ? 63 : x0;
      x1 = ($urandom_range(0, 2) == 0) ? x0 : $urandom_range(0, 16);
      a0 = {x0[5:0], 2'($urandom_range(0, 3))};
      a1 = {x1[5:0], 2'($urandom_range(0, 3))};
      irq_acc = (e0 && e1) ? 32'h0 : 32'($urandom_range(0, 15));
      run_pair($sformatf("rnd%0d", it), e0, a0, w0, $urandom, e1, a1, w1, $urandom, irq_acc);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
